// File: rtl/feeder_dispense_ctrl_pkg.sv
// Shared state encodings and widths for the feeder timer/dispense stages.
package feeder_dispense_ctrl_pkg;

    localparam int unsigned PORC_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

endpackage

// File: rtl/feeder_dispense_ctrl_sensor_debounce.sv
// Portion sensor conditioning: 2-FF synchronizer, level debouncer and
// registered rising-edge pulse of the debounced level.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    output logic level,
    output logic rise
);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] db_cnt;

    // Level only follows sync2 after it has held the new value long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            rise    <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= sensor_raw;
            sync2   <= sync1;
            level_q <= level;
            rise    <= level & ~level_q;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/feeder_dispense_ctrl.sv
// Dispensing motor controller: runs the motor until the requested number of
// debounced portion edges is seen, with inter-portion gaps and jam detection.
module feeder_dispense_ctrl
    import feeder_dispense_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_m_on,
    input  logic [PORC_W-1:0] porciones,
    input  logic              sensor_raw,
    input  logic              i_clear,
    output logic              o_motor_on,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fault,
    output logic [PORC_W-1:0] o_count
);

    state_t            state, state_d;
    logic [PORC_W-1:0] target, target_d;
    logic [PORC_W-1:0] count_d;
    logic [CNT_W-1:0]  timer, timer_d;
    logic              i_m_on_q;
    logic              trig;
    logic              portion_evt;
    logic              sensor_level_unused;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sensor_debounce (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .level      (sensor_level_unused),
        .rise       (portion_evt)
    );

    assign trig = i_m_on & ~i_m_on_q;

    // State, counters and registered outputs; outputs lag the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            target     <= '0;
            timer      <= '0;
            i_m_on_q   <= 1'b0;
            o_count    <= '0;
            o_motor_on <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_fault    <= 1'b0;
        end else begin
            state      <= state_d;
            target     <= target_d;
            timer      <= timer_d;
            i_m_on_q   <= i_m_on;
            o_count    <= count_d;
            o_motor_on <= (state == ST_RUN);
            o_busy     <= (state == ST_LOAD) || (state == ST_RUN) || (state == ST_GAP);
            o_done     <= (state == ST_DONE);
            o_fault    <= (state == ST_FAULT);
        end
    end

    // Next-state logic; the shared timer serves both RUN timeout and GAP pause.
    always_comb begin
        state_d  = state;
        target_d = target;
        timer_d  = timer;
        count_d  = o_count;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_d  = ST_LOAD;
                    target_d = porciones;
                end
            end
            ST_LOAD: begin
                count_d = '0;
                timer_d = '0;
                state_d = (target == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (portion_evt) begin
                    count_d = (o_count == '1) ? o_count : o_count + PORC_W'(1);
                    timer_d = '0;
                    state_d = (count_d == target) ? ST_DONE : ST_GAP;
                end else if (timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (timer == CNT_W'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (trig) begin
                    state_d  = ST_LOAD;
                    target_d = porciones;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (i_clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
